adc_spi_capture: RTL and testbench

- SPI master for the hydrophone-channel 10-bit serial ADC (ADC101S021-style framing).
- Converts at a fixed sample rate and presents each result as a 10-bit word with a multi-cycle ready strobe.
- Directly upstream of the ring buffer and trigger/FFT stage; sample_data and sample_ready drive their Input_Data/Input_Data_Ready and data_ready inputs.

---
 rtl/adc_pkg.sv | 25 ++
 rtl/adc_spi_capture_if.sv | 34 +++
 rtl/adc_sclk_gen.sv | 37 +++
 rtl/adc_spi_capture.sv | 183 ++++++++++++++++++
 tb/tb_adc_spi_capture.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the hydrophone ADC SPI capture block.
package adc_pkg;

   localparam int CLK_DIV       = 4;
   localparam int FRAME_BITS    = 16;
   localparam int LEAD_BITS     = 3;
   localparam int DATA_BITS     = 10;
   localparam int CS_SETUP      = 2;
   localparam int CS_HOLD       = 2;
   localparam int SAMPLE_PERIOD = 196;
   localparam int READY_HOLD    = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Bits needed to hold any value 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/adc_spi_capture_if.sv
// ADC-side SPI pins and sample output bus of the capture block.
interface adc_spi_capture_if #(
   parameter int SAMPLE_W = adc_pkg::DATA_BITS
) ();

   logic                enable;
   logic                adc_miso;
   logic                adc_sclk;
   logic                adc_cs_n;
   logic [SAMPLE_W-1:0] sample_data;
   logic                sample_ready;
   logic                lead_error;

   modport master (
      input  enable,
      input  adc_miso,
      output adc_sclk,
      output adc_cs_n,
      output sample_data,
      output sample_ready,
      output lead_error
   );

   modport slave (
      output enable,
      output adc_miso,
      input  adc_sclk,
      input  adc_cs_n,
      input  sample_data,
      input  sample_ready,
      input  lead_error
   );

endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK half-period divider: idles high, first edge after run rises is a fall.
module adc_sclk_gen #(
   parameter int CLK_DIV = adc_pkg::CLK_DIV
) (
   input  logic clk,
   input  logic reset_b,
   input  logic run,
   output logic sclk,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int DW = adc_pkg::cnt_width(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          half_end;

   assign half_end  = run && (div_cnt == '0);
   assign rise_tick = half_end && !sclk;
   assign fall_tick = half_end && sclk;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sclk    <= 1'b1;
         div_cnt <= '0;
      end else if (!run) begin
         sclk    <= 1'b1;
         div_cnt <= '0;
      end else if (half_end) begin
         sclk    <= !sclk;
         div_cnt <= DW'(CLK_DIV - 1);
      end else begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/adc_spi_capture.sv
// SPI master for the 10-bit hydrophone ADC: periodic frames, sample register,
// multi-cycle ready strobe and sticky leading-bit error.
//
// state | meaning
// IDLE  | cs_n high, waiting for period counter start
// SETUP | cs_n low, sclk high, CS_SETUP cycles before first fall
// SHIFT | FRAME_BITS sclk periods, then one sclk-high half of tail
// HOLD  | cs_n low, sclk high, CS_HOLD cycles; exit publishes sample
module adc_spi_capture #(
   parameter int CLK_DIV       = adc_pkg::CLK_DIV,
   parameter int FRAME_BITS    = adc_pkg::FRAME_BITS,
   parameter int LEAD_BITS     = adc_pkg::LEAD_BITS,
   parameter int DATA_BITS     = adc_pkg::DATA_BITS,
   parameter int CS_SETUP      = adc_pkg::CS_SETUP,
   parameter int CS_HOLD       = adc_pkg::CS_HOLD,
   parameter int SAMPLE_PERIOD = adc_pkg::SAMPLE_PERIOD,
   parameter int READY_HOLD    = adc_pkg::READY_HOLD
) (
   input  logic              clk,
   input  logic              reset_b,
   adc_spi_capture_if.master bus
);

   import adc_pkg::*;

   if (SAMPLE_PERIOD < CS_SETUP + 2*CLK_DIV*FRAME_BITS + CS_HOLD + READY_HOLD + 1) begin : g_bad_period
      $error("SAMPLE_PERIOD too short for one frame plus ready pulse");
   end
   if (LEAD_BITS + DATA_BITS > FRAME_BITS) begin : g_bad_frame
      $error("LEAD_BITS + DATA_BITS exceeds FRAME_BITS");
   end

   localparam int BW = cnt_width(FRAME_BITS);
   localparam int TW = cnt_width(CS_SETUP + CLK_DIV + CS_HOLD);
   localparam int PW = cnt_width(SAMPLE_PERIOD - 1);
   localparam int RW = cnt_width(READY_HOLD);

   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] ALL_BITS = BW'(FRAME_BITS);
   localparam logic [BW-1:0] DATA_LO  = BW'(LEAD_BITS);
   localparam logic [BW-1:0] DATA_HI  = BW'(LEAD_BITS + DATA_BITS);

   state_t                state;
   state_t                state_nxt;
   logic [PW-1:0]         per_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [TW-1:0]         tmr;
   logic [RW-1:0]         rdy_cnt;
   logic [DATA_BITS-1:0]  shreg;
   logic [DATA_BITS-1:0]  sample_data_r;
   logic                  sample_ready_r;
   logic                  lead_error_r;
   logic                  cs_n_r;
   logic                  sclk;
   logic                  sclk_run;
   logic                  rise_tick;
   logic                  fall_tick;
   logic                  tmr_zero;
   logic                  start;
   logic                  frame_done;

   assign tmr_zero = (tmr == '0);
   assign start    = bus.enable && (per_cnt == '0) && (state == IDLE);
   // Divider runs from the last SETUP cycle (so the first fall lands on the
   // SHIFT entry edge) until the final rise; the tail half is timed by tmr.
   assign sclk_run = ((state == SETUP) && tmr_zero) ||
                     ((state == SHIFT) && (bit_cnt != ALL_BITS));

   adc_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk       (clk),
      .reset_b   (reset_b),
      .run       (sclk_run),
      .sclk      (sclk),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = SETUP;
         SETUP: if (fall_tick) state_nxt = SHIFT;
         SHIFT: if ((bit_cnt == ALL_BITS) && tmr_zero) state_nxt = HOLD;
         HOLD: begin
            if (tmr_zero) begin
               state_nxt  = IDLE;
               frame_done = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Down-counting period timer; a start fires on its terminal count.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         per_cnt <= '0;
      end else if (!bus.enable) begin
         per_cnt <= '0;
      end else if (per_cnt == '0) begin
         per_cnt <= PW'(SAMPLE_PERIOD - 1);
      end else begin
         per_cnt <= per_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cs_n_r        <= 1'b1;
         tmr           <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         sample_data_r <= '0;
         lead_error_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cs_n_r  <= 1'b0;
                  tmr     <= TW'(CS_SETUP - 1);
                  bit_cnt <= '0;
                  shreg   <= '0;
               end
            end
            SETUP: begin
               if (!tmr_zero) tmr <= tmr - 1'b1;
            end
            SHIFT: begin
               if (rise_tick) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if ((bit_cnt < DATA_LO) && bus.adc_miso) lead_error_r <= 1'b1;
                  if ((bit_cnt >= DATA_LO) && (bit_cnt < DATA_HI))
                     shreg <= {shreg[DATA_BITS-2:0], bus.adc_miso};
                  if (bit_cnt == LAST_BIT) tmr <= TW'(CLK_DIV - 1);
               end else if (bit_cnt == ALL_BITS) begin
                  if (tmr_zero) tmr <= TW'(CS_HOLD - 1);
                  else          tmr <= tmr - 1'b1;
               end
            end
            HOLD: begin
               if (tmr_zero) begin
                  cs_n_r        <= 1'b1;
                  sample_data_r <= shreg;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: cs_n_r <= 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sample_ready_r <= 1'b0;
         rdy_cnt        <= '0;
      end else if (frame_done) begin
         sample_ready_r <= 1'b1;
         rdy_cnt        <= RW'(READY_HOLD - 1);
      end else if (sample_ready_r) begin
         if (rdy_cnt == '0) sample_ready_r <= 1'b0;
         else               rdy_cnt        <= rdy_cnt - 1'b1;
      end
   end

   assign bus.adc_sclk     = sclk;
   assign bus.adc_cs_n     = cs_n_r;
   assign bus.sample_data  = sample_data_r;
   assign bus.sample_ready = sample_ready_r;
   assign bus.lead_error   = lead_error_r;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: ADC frame model, event monitor, table, random
// and hand-written corner sequences.
module tb_adc_spi_capture;

   import adc_pkg::*;

   typedef struct {
      logic [15:0] frame;
      logic [9:0]  exp_data;
      logic        exp_lead;
   } vec_t;

   logic clk = 1'b0;
   logic reset_b;
   logic miso_drv = 1'b0;

   adc_spi_capture_if #(.SAMPLE_W(10)) bus ();

   adc_spi_capture dut (
      .clk     (clk),
      .reset_b (reset_b),
      .bus     (bus.master)
   );

   assign bus.adc_miso = miso_drv;

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Frames the ADC model returns, one per cs_n fall, in order.
   logic [15:0] frm[$];
   int          fidx = 0;
   logic [15:0] cur  = '0;

   // Monitor results.
   int          fall_q[$];
   int          low_q[$];
   int          rises_q[$];
   int          rdyl_q[$];
   logic [9:0]  data_q[$];
   logic        lead_q[$];
   int          cs_cnt = 0;
   int          rise_cnt = 0;
   int          rdy_cnt = 0;
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b1;
   logic        prev_rdy = 1'b0;

   int bf, bl, bs, br, bd;

   // ADC: cs_n fall loads the next frame; each sclk fall presents the next bit.
   always @(negedge bus.adc_cs_n or negedge bus.adc_sclk) begin
      if (!bus.adc_cs_n) begin
         if (bus.adc_sclk) begin
            miso_drv <= 1'b0;
            if (fidx < frm.size()) begin
               cur  <= frm[fidx];
               fidx <= fidx + 1;
            end else begin
               cur <= '0;
            end
         end else if (rise_cnt < 16) begin
            miso_drv <= cur[15 - rise_cnt];
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_b) begin
         cs_cnt    <= 0;
         rise_cnt  <= 0;
         rdy_cnt   <= 0;
         prev_cs   <= 1'b1;
         prev_sclk <= 1'b1;
         prev_rdy  <= 1'b0;
      end else begin
         if (prev_cs && !bus.adc_cs_n) fall_q.push_back(cyc);
         if (!bus.adc_cs_n) cs_cnt <= cs_cnt + 1;
         if (!bus.adc_cs_n && !prev_sclk && bus.adc_sclk) rise_cnt <= rise_cnt + 1;
         if (!prev_cs && bus.adc_cs_n) begin
            low_q.push_back(cs_cnt);
            rises_q.push_back(rise_cnt);
            cs_cnt   <= 0;
            rise_cnt <= 0;
         end
         if (bus.sample_ready) rdy_cnt <= rdy_cnt + 1;
         if (!prev_rdy && bus.sample_ready) begin
            data_q.push_back(bus.sample_data);
            lead_q.push_back(bus.lead_error);
         end
         if (prev_rdy && !bus.sample_ready) begin
            rdyl_q.push_back(rdy_cnt);
            rdy_cnt <= 0;
         end
         prev_cs   <= bus.adc_cs_n;
         prev_sclk <= bus.adc_sclk;
         prev_rdy  <= bus.sample_ready;
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic mark();
      bf = fall_q.size();
      bl = low_q.size();
      bs = rises_q.size();
      br = rdyl_q.size();
      bd = data_q.size();
   endtask

   task automatic timeout(input string nm, input int budget);
      total++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles", nm, budget);
   endtask

   task automatic wait_frames(input string nm, input int n, input int budget);
      int k = 0;
      while (!(data_q.size() >= bd + n && rdyl_q.size() >= br + n) && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) timeout(nm, budget);
   endtask

   task automatic wait_rises(input string nm, input int n, input int budget);
      int k = 0;
      while (rise_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) timeout(nm, budget);
   endtask

   task automatic do_reset();
      bus.enable = 1'b0;
      reset_b    = 1'b0;
      repeat (3) @(negedge clk);
      reset_b = 1'b1;
   endtask

   task automatic check_frame(input string nm, input int i, input logic [9:0] d, input logic ld);
      check({nm, "_data"},  int'(data_q[bd+i]), int'(d));
      check({nm, "_lead"},  int'(lead_q[bd+i]), int'(ld));
      check({nm, "_cslow"}, low_q[bl+i], 132);
      check({nm, "_rises"}, rises_q[bs+i], 16);
      check({nm, "_rdy"},   rdyl_q[br+i], 14);
   endtask

   vec_t        vecs[7];
   logic [15:0] rf;
   logic [9:0]  rexp_d[$];
   logic        rexp_l[$];
   logic        lead_model;
   int          c0;

   initial begin
      vecs[0] = '{16'h1528, 10'h2A5, 1'b0};
      vecs[1] = '{16'h0000, 10'h000, 1'b0};
      vecs[2] = '{16'h1FF8, 10'h3FF, 1'b0};
      vecs[3] = '{16'h0AA8, 10'h155, 1'b0};
      vecs[4] = '{16'h0AAF, 10'h155, 1'b0};
      vecs[5] = '{16'h4780, 10'h0F0, 1'b1};
      vecs[6] = '{16'h0918, 10'h123, 1'b1};

      bus.enable = 1'b0;
      reset_b    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sclk",  int'(bus.adc_sclk), 1);
      check("rst_cs_n",  int'(bus.adc_cs_n), 1);
      check("rst_data",  int'(bus.sample_data), 0);
      check("rst_ready", int'(bus.sample_ready), 0);
      check("rst_lead",  int'(bus.lead_error), 0);
      reset_b = 1'b1;

      // Table: periodic run through all vectors.
      mark();
      foreach (vecs[i]) frm.push_back(vecs[i].frame);
      @(negedge clk);
      bus.enable = 1'b1;
      wait_frames("tbl_wait", 7, 7*196 + 300);
      bus.enable = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check_frame($sformatf("tbl%0d", i), i, vecs[i].exp_data, vecs[i].exp_lead);
         if (i > 0) check($sformatf("tbl%0d_spacing", i), fall_q[bf+i] - fall_q[bf+i-1], 196);
      end
      check("lead_sticky", int'(bus.lead_error), 1);

      // Random frames against the arithmetic model.
      do_reset();
      mark();
      lead_model = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rf = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) != 0) rf = rf & 16'h1FFF;
         frm.push_back(rf);
         rexp_d.push_back(10'((rf >> 3) & 16'h03FF));
         lead_model = lead_model | ((rf >> 13) != 16'h0);
         rexp_l.push_back(lead_model);
      end
      @(negedge clk);
      bus.enable = 1'b1;
      wait_frames("rnd_wait", 6, 6*196 + 300);
      bus.enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rnd%0d_data", i), int'(data_q[bd+i]), int'(rexp_d[i]));
         check($sformatf("rnd%0d_lead", i), int'(lead_q[bd+i]), int'(rexp_l[i]));
         if (i > 0) check($sformatf("rnd%0d_spacing", i), fall_q[bf+i] - fall_q[bf+i-1], 196);
      end

      // Enable drop at bit 8: frame completes, nothing further starts.
      do_reset();
      mark();
      frm.push_back(16'h1698);
      @(negedge clk);
      bus.enable = 1'b1;
      wait_rises("drop_rises", 8, 300);
      bus.enable = 1'b0;
      wait_frames("drop_wait", 1, 400);
      check_frame("drop", 0, 10'h2D3, 1'b0);
      repeat (400) @(negedge clk);
      check("drop_nofall", fall_q.size() - bf, 1);
      check("drop_cs_high", int'(bus.adc_cs_n), 1);

      // Reassert: first fall on the first sampled edge, then regular spacing.
      mark();
      frm.push_back(16'h0E38);
      frm.push_back(16'h1528);
      @(negedge clk);
      c0 = cyc;
      bus.enable = 1'b1;
      wait_frames("reen_wait", 2, 2*196 + 300);
      bus.enable = 1'b0;
      check("reen_first_fall", fall_q[bf] - c0, 1);
      check("reen_spacing", fall_q[bf+1] - fall_q[bf], 196);
      check("reen_data0", int'(data_q[bd]), 10'h1C7);
      check("reen_data1", int'(data_q[bd+1]), 10'h2A5);

      // Reset during the low half of bit 5.
      do_reset();
      frm.push_back(16'h1528);
      @(negedge clk);
      bus.enable = 1'b1;
      wait_rises("mid_rises", 5, 300);
      @(negedge clk);
      #2 reset_b = 1'b0;
      #1;
      check("mid_sclk",  int'(bus.adc_sclk), 1);
      check("mid_cs_n",  int'(bus.adc_cs_n), 1);
      check("mid_data",  int'(bus.sample_data), 0);
      check("mid_ready", int'(bus.sample_ready), 0);
      check("mid_lead",  int'(bus.lead_error), 0);
      repeat (3) @(negedge clk);
      check("mid_data_held", int'(bus.sample_data), 0);
      mark();
      frm.push_back(16'h0E38);
      reset_b = 1'b1;
      wait_frames("post_wait", 1, 400);
      bus.enable = 1'b0;
      check_frame("post", 0, 10'h1C7, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
